// File: rtl/ahb_lite_fifo_master_pkg.sv
// Shared command-word layout and AHB-Lite encodings for the FIFO-driven bus master.
package ahb_lite_fifo_master_pkg;

  // Command word: [35] write, [34:32] size, [31:0] addr
  localparam int CMD_FIFO_DATA_WIDTH = 36;

  localparam logic [1:0] AHB_TRANS_IDLE   = 2'b00;
  localparam logic [1:0] AHB_TRANS_NONSEQ = 2'b10;
  localparam logic [2:0] AHB_BURST_SINGLE = 3'b000;
  localparam logic [2:0] AHB_SIZE_BYTE    = 3'b000;
  localparam logic [2:0] AHB_SIZE_HALF    = 3'b001;
  localparam logic [2:0] AHB_SIZE_WORD    = 3'b010;
  localparam logic [3:0] AHB_PROT_DEFAULT = 4'b0011;

  typedef struct packed {
    logic        write;
    logic [2:0]  size;
    logic [31:0] addr;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REJ,
    S_ADDR,
    S_DATA,
    S_ERR
  } state_t;

  // Unsupported size or an address not aligned to the transfer size.
  function automatic logic cmd_bad(input cmd_t c);
    return (c.size > AHB_SIZE_WORD) ||
           ((c.size == AHB_SIZE_HALF) && c.addr[0]) ||
           ((c.size == AHB_SIZE_WORD) && (c.addr[1:0] != 2'b00));
  endfunction

endpackage

// File: rtl/ahb_lite_fifo_master.sv
// AHB-Lite initiator: pops commands (and write data) from FIFOs, runs one
// SINGLE transfer at a time, and pushes read data (or an error word) to a FIFO.
module ahb_lite_fifo_master
  import ahb_lite_fifo_master_pkg::*;
#(
  parameter logic [31:0] ERR_DATA      = 32'hDEAD_BEEF,
  parameter int          ERR_CNT_WIDTH = 8
) (
  input  logic                           HCLK,
  input  logic                           HRESET,
  output logic                           CFIFO_REN,
  input  logic [CMD_FIFO_DATA_WIDTH-1:0] CFIFO_RDATA,
  input  logic                           CFIFO_REMPTY,
  output logic                           WFIFO_REN,
  input  logic [31:0]                    WFIFO_RDATA,
  input  logic                           WFIFO_REMPTY,
  output logic                           RFIFO_WEN,
  output logic [31:0]                    RFIFO_WDATA,
  input  logic                           RFIFO_WFULL,
  output logic [31:0]                    HADDR,
  output logic [2:0]                     HBURST,
  output logic                           HMASTLOCK,
  output logic [3:0]                     HPROT,
  output logic [2:0]                     HSIZE,
  output logic [1:0]                     HTRANS,
  output logic                           HWRITE,
  output logic [31:0]                    HWDATA,
  input  logic [31:0]                    HRDATA,
  input  logic                           HREADY,
  input  logic                           HRESP,
  output logic                           BUSY,
  output logic [ERR_CNT_WIDTH-1:0]       ERR_COUNT
);

  localparam logic [ERR_CNT_WIDTH-1:0] CNT_ONE = 1;

  state_t state, state_nxt;
  cmd_t   cmd_q;
  cmd_t   head;
  logic   eligible;
  logic   err_inc;

  assign head = cmd_t'(CFIFO_RDATA);
  // Read eligibility reserves the RFIFO slot, so later pushes never stall.
  assign eligible = !CFIFO_REMPTY && (head.write ? !WFIFO_REMPTY : !RFIFO_WFULL);

  assign HADDR     = cmd_q.addr;
  assign HSIZE     = cmd_q.size;
  assign HWRITE    = cmd_q.write;
  assign HBURST    = AHB_BURST_SINGLE;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = AHB_PROT_DEFAULT;
  assign BUSY      = (state != S_IDLE);

  // State register; async reset drops HTRANS/BUSY without waiting for a clock.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state, FIFO strobes, bus control and error-count request.
  always_comb begin
    state_nxt   = state;
    CFIFO_REN   = 1'b0;
    WFIFO_REN   = 1'b0;
    RFIFO_WEN   = 1'b0;
    RFIFO_WDATA = '0;
    HTRANS      = AHB_TRANS_IDLE;
    err_inc     = 1'b0;
    case (state)
      S_IDLE: begin
        if (eligible) begin
          CFIFO_REN = 1'b1;
          WFIFO_REN = head.write;
          if (cmd_bad(head)) begin
            err_inc   = 1'b1;
            state_nxt = S_REJ;
          end else begin
            state_nxt = S_ADDR;
          end
        end
      end
      S_REJ: begin
        RFIFO_WEN   = !cmd_q.write;
        RFIFO_WDATA = ERR_DATA;
        state_nxt   = S_IDLE;
      end
      S_ADDR: begin
        HTRANS = AHB_TRANS_NONSEQ;
        if (HREADY) state_nxt = S_DATA;
      end
      S_DATA: begin
        if (HREADY) begin
          // A slave skipping the first ERROR cycle is still treated as an error.
          RFIFO_WEN   = !cmd_q.write;
          RFIFO_WDATA = HRESP ? ERR_DATA : HRDATA;
          err_inc     = HRESP;
          state_nxt   = S_IDLE;
        end else if (HRESP) begin
          state_nxt = S_ERR;
        end
      end
      S_ERR: begin
        if (HREADY) begin
          RFIFO_WEN   = !cmd_q.write;
          RFIFO_WDATA = ERR_DATA;
          err_inc     = 1'b1;
          state_nxt   = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Command and write-data latch, loaded on the CFIFO pop.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      cmd_q  <= '0;
      HWDATA <= '0;
    end else if (CFIFO_REN) begin
      cmd_q <= head;
      if (head.write) HWDATA <= WFIFO_RDATA;
    end
  end

  // Saturating error counter; sticks at all-ones.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)                      ERR_COUNT <= '0;
    else if (err_inc && ~&ERR_COUNT) ERR_COUNT <= ERR_COUNT + CNT_ONE;
  end

endmodule
